// File: rtl/mcpu_selftest_sequencer_if.sv
// Program-RAM write port, program/check streams and register-file read port of the MCPU self-test sequencer.
// master = sequencer side, slave = RAM / stream sources / register file.
interface mcpu_selftest_sequencer_if #(
    parameter int WORD_SIZE      = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 4
);
    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [WORD_SIZE-1:0]      mem_wdata;
    logic                      prog_valid;
    logic                      prog_ready;
    logic [WORD_SIZE-1:0]      prog_data;
    logic                      prog_last;
    logic                      chk_valid;
    logic                      chk_ready;
    logic [REG_ADDR_WIDTH-1:0] chk_reg;
    logic [DATA_WIDTH-1:0]     chk_value;
    logic                      chk_last;
    logic [REG_ADDR_WIDTH-1:0] reg_raddr;
    logic [DATA_WIDTH-1:0]     reg_rdata;

    modport master (
        output mem_we, mem_addr, mem_wdata, prog_ready, chk_ready, reg_raddr,
        input  prog_valid, prog_data, prog_last, chk_valid, chk_reg, chk_value, chk_last, reg_rdata
    );
    modport slave (
        input  mem_we, mem_addr, mem_wdata, prog_ready, chk_ready, reg_raddr,
        output prog_valid, prog_data, prog_last, chk_valid, chk_reg, chk_value, chk_last, reg_rdata
    );
endinterface

// File: rtl/mcpu_selftest_sequencer.sv
// MCPU self-test sequencer: zero-fill RAM, stream in program, run for RUN_CYCLES, check registers.
// Optional MCPU_SELFTEST_TRACE_EN: consume every check entry and report mismatch count / first mismatch.
module mcpu_selftest_sequencer #(
    parameter int WORD_SIZE      = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int RUN_CYCLES     = 57
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    mcpu_selftest_sequencer_if.master bus,
    output logic cpu_reset,
    output logic busy,
    output logic done,
    output logic pass,
    output logic load_ovf
`ifdef MCPU_SELFTEST_TRACE_EN
    ,
    output logic [REG_ADDR_WIDTH:0]   fail_count,
    output logic [REG_ADDR_WIDTH-1:0] first_fail_reg,
    output logic [DATA_WIDTH-1:0]     first_fail_data
`endif
);
    localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [RUN_W-1:0]      RUN_LAST  = RUN_W'(RUN_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, CHECK, DONE} state_t;

    state_t                    state, state_nx;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [RUN_W-1:0]          run_cnt;
    logic                      fail;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [REG_ADDR_WIDTH-1:0] chk_reg;
    logic                      restart, prog_hs, chk_hs, mismatch, chk_end;

    assign rdata    = bus.reg_rdata;
    assign chk_reg  = bus.chk_reg;
    assign restart  = start && (state == IDLE || state == DONE);
    assign prog_hs  = (state == LOAD) && bus.prog_valid;
    assign chk_hs   = (state == CHECK) && bus.chk_valid;
    assign mismatch = rdata != bus.chk_value;
`ifdef MCPU_SELFTEST_TRACE_EN
    assign chk_end  = chk_hs && bus.chk_last;
`else
    assign chk_end  = chk_hs && (bus.chk_last || mismatch);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: if (start) state_nx = CLEAR;
            CLEAR:      if (addr == LAST_ADDR) state_nx = LOAD;
            LOAD:       if (prog_hs && (bus.prog_last || addr == LAST_ADDR)) state_nx = RUN;
            RUN:        if (run_cnt == RUN_LAST) state_nx = CHECK;
            CHECK:      if (chk_end) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        cpu_reset      = 1'b1;
        busy           = 1'b0;
        done           = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = WORD_SIZE'(0);
        bus.prog_ready = 1'b0;
        bus.chk_ready  = 1'b0;
        unique case (state)
            CLEAR: begin
                busy       = 1'b1;
                bus.mem_we = 1'b1;
            end
            LOAD: begin
                busy           = 1'b1;
                bus.prog_ready = 1'b1;
                bus.mem_we     = bus.prog_valid;
                bus.mem_wdata  = WORD_SIZE'(bus.prog_data);
            end
            RUN: begin
                busy      = 1'b1;
                cpu_reset = 1'b0;
            end
            CHECK: begin
                busy          = 1'b1;
                bus.chk_ready = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign bus.mem_addr  = addr;
    assign bus.reg_raddr = chk_reg;
    assign pass          = (state == DONE) && !fail && !load_ovf;

    // One counter walks CLEAR addresses and then serves as the load pointer; CLEAR's
    // natural wrap to 0 primes LOAD, and LOAD holds it at the top address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr     <= '0;
            run_cnt  <= '0;
            fail     <= 1'b0;
            load_ovf <= 1'b0;
        end else begin
            if (restart) begin
                addr     <= '0;
                fail     <= 1'b0;
                load_ovf <= 1'b0;
            end else begin
                if (state == CLEAR || (prog_hs && addr != LAST_ADDR))
                    addr <= addr + ADDR_WIDTH'(1);
                if (prog_hs && addr == LAST_ADDR && !bus.prog_last)
                    load_ovf <= 1'b1;
                if (chk_hs && mismatch)
                    fail <= 1'b1;
            end
            run_cnt <= (state == RUN) ? run_cnt + RUN_W'(1) : '0;
        end
    end

`ifdef MCPU_SELFTEST_TRACE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_count      <= '0;
            first_fail_reg  <= '0;
            first_fail_data <= '0;
        end else if (restart) begin
            fail_count      <= '0;
            first_fail_reg  <= '0;
            first_fail_data <= '0;
        end else if (chk_hs && mismatch) begin
            if (fail_count != '1) fail_count <= fail_count + (REG_ADDR_WIDTH+1)'(1);
            if (!fail) begin
                first_fail_reg  <= chk_reg;
                first_fail_data <= rdata;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mcpu_selftest_sequencer.sv
// Directed bench: a default-size sequencer (256-word RAM) and a 3-bit-address one for overflow,
// sharing the stream inputs; a register-file model holds the values the test program leaves behind.
module tb_mcpu_selftest_sequencer;
    logic        clk = 1'b0, reset = 1'b1, start0 = 1'b0, start1 = 1'b0;
    logic        prog_valid = 1'b0, prog_last = 1'b0;
    logic [15:0] prog_data = '0;
    logic        chk_valid = 1'b0, chk_last = 1'b0;
    logic [3:0]  chk_reg = '0;
    logic [7:0]  chk_value = '0;
    logic        cpu_reset0, busy0, done0, pass0, load_ovf0;
    logic        cpu_reset1, busy1, done1, pass1, load_ovf1;
    logic [7:0]  rf [16];
    logic [15:0] prog [16];
    logic [15:0] ram0 [256];
    logic [15:0] ram1 [8];
    int          clr0 = 0, clr1 = 0, clr_bad0 = 0, clr_bad1 = 0, ld0 = 0, ld1 = 0, run0 = 0, run1 = 0;
    int          n_tests = 0, n_fail = 0;
`ifdef MCPU_SELFTEST_TRACE_EN
    logic [4:0]  fail_count0, fail_count1;
    logic [3:0]  first_fail_reg0, first_fail_reg1;
    logic [7:0]  first_fail_data0, first_fail_data1;
`endif

    always #5 clk = ~clk;

    mcpu_selftest_sequencer_if #(.ADDR_WIDTH(8)) if0 ();
    mcpu_selftest_sequencer_if #(.ADDR_WIDTH(3)) if1 ();

    assign if0.prog_valid = prog_valid;  assign if1.prog_valid = prog_valid;
    assign if0.prog_data  = prog_data;   assign if1.prog_data  = prog_data;
    assign if0.prog_last  = prog_last;   assign if1.prog_last  = prog_last;
    assign if0.chk_valid  = chk_valid;   assign if1.chk_valid  = chk_valid;
    assign if0.chk_reg    = chk_reg;     assign if1.chk_reg    = chk_reg;
    assign if0.chk_value  = chk_value;   assign if1.chk_value  = chk_value;
    assign if0.chk_last   = chk_last;    assign if1.chk_last   = chk_last;
    assign if0.reg_rdata  = rf[if0.reg_raddr];
    assign if1.reg_rdata  = rf[if1.reg_raddr];

    mcpu_selftest_sequencer #(.ADDR_WIDTH(8), .RUN_CYCLES(57)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .bus(if0.master),
        .cpu_reset(cpu_reset0), .busy(busy0), .done(done0), .pass(pass0), .load_ovf(load_ovf0)
`ifdef MCPU_SELFTEST_TRACE_EN
        , .fail_count(fail_count0), .first_fail_reg(first_fail_reg0), .first_fail_data(first_fail_data0)
`endif
    );

    mcpu_selftest_sequencer #(.ADDR_WIDTH(3), .RUN_CYCLES(57)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .bus(if1.master),
        .cpu_reset(cpu_reset1), .busy(busy1), .done(done1), .pass(pass1), .load_ovf(load_ovf1)
`ifdef MCPU_SELFTEST_TRACE_EN
        , .fail_count(fail_count1), .first_fail_reg(first_fail_reg1), .first_fail_data(first_fail_data1)
`endif
    );

    // RAM model and activity counters; CLEAR writes must walk addresses in order with zero data.
    always @(posedge clk) begin
        if (if0.mem_we) begin
            ram0[if0.mem_addr] <= if0.mem_wdata;
            if (if0.prog_ready) ld0 <= ld0 + 1;
            else begin
                if (if0.mem_addr != clr0[7:0] || if0.mem_wdata != 16'h0) clr_bad0 <= clr_bad0 + 1;
                clr0 <= clr0 + 1;
            end
        end
        if (if1.mem_we) begin
            ram1[if1.mem_addr] <= if1.mem_wdata;
            if (if1.prog_ready) ld1 <= ld1 + 1;
            else begin
                if (if1.mem_addr != clr1[2:0] || if1.mem_wdata != 16'h0) clr_bad1 <= clr_bad1 + 1;
                clr1 <= clr1 + 1;
            end
        end
        if (!cpu_reset0) run0 <= run0 + 1;
        if (!cpu_reset1) run1 <= run1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic bit sig(input int code);
        case (code)
            0:       return if0.prog_ready;
            1:       return if0.chk_ready;
            2:       return if1.prog_ready;
            3:       return if1.chk_ready;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int code, input int limit);
        int t = 0;
        @(negedge clk); #1;
        while (!sig(code) && t < limit) begin
            @(negedge clk); #1;
            t++;
        end
        check(tag, 32'(sig(code)), 1);
    endtask

    task automatic pulse_start(input bit inst);
        @(negedge clk);
        if (inst) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic send_word(input bit inst, input logic [15:0] d, input bit last, output bit took);
        took = 1'b0;
        @(negedge clk);
        prog_valid = 1'b1; prog_data = d; prog_last = last;
        for (int t = 0; t < 4 && !took; t++) begin
            #1;
            if (sig(inst ? 2 : 0)) begin @(posedge clk); took = 1'b1; end
            else @(negedge clk);
        end
    endtask

    task automatic load_program(input bit inst, input int n, input bit mark_last, input bit do_stall,
                                output int acc);
        bit took;
        acc = 0;
        for (int w = 0; w < n; w++) begin
            if (do_stall && w == 8) begin
                @(negedge clk);
                prog_valid = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    check("stall_prog_ready", 32'(if0.prog_ready), 1);
                    check("stall_mem_we", 32'(if0.mem_we), 0);
                    check("stall_pointer", 32'(if0.mem_addr), 8);
                    if (s < 4) @(negedge clk);
                end
            end
            send_word(inst, prog[w % 16], mark_last && w == n - 1, took);
            if (!took) break;
            acc++;
        end
        @(negedge clk);
        prog_valid = 1'b0; prog_last = 1'b0;
    endtask

    task automatic send_entry(input bit inst, input logic [3:0] r, input logic [7:0] v, input bit last,
                              output bit took);
        took = 1'b0;
        @(negedge clk);
        chk_valid = 1'b1; chk_reg = r; chk_value = v; chk_last = last;
        for (int t = 0; t < 4 && !took; t++) begin
            #1;
            if (sig(inst ? 3 : 1)) begin @(posedge clk); took = 1'b1; end
            else @(negedge clk);
        end
    endtask

    task automatic end_entries();
        @(negedge clk);
        chk_valid = 1'b0; chk_last = 1'b0;
        #1;
    endtask

    function automatic int ram_diff(input bit inst, input int n);
        int d = 0;
        for (int i = 0; i < n; i++)
            if ((inst ? ram1[i % 8] : ram0[i % 256]) !== prog[i]) d++;
        return d;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc, base_clr, base_run, base_ld;
        bit  took;
        int  n_took;

        rf[0] = 8'd44;  rf[1] = 8'd56;  rf[2] = 8'd44;  rf[3] = 8'd56;
        rf[4] = 8'd100; rf[5] = 8'd20;  rf[6] = 8'd44;  rf[7] = 8'd56;
        rf[8] = 8'd44;  rf[9] = 8'd56;  rf[10] = 8'd40; rf[11] = 8'd60;
        rf[12] = 8'd0;  rf[13] = 8'd0;  rf[14] = 8'd0;  rf[15] = 8'd0;
        for (int i = 0; i < 16; i++) prog[i] = 16'hA000 + 16'(i * 16'h0111);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_cpu_reset", 32'(cpu_reset0), 1);
        check("rst_busy", 32'(busy0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_pass", 32'(pass0), 0);
        check("rst_load_ovf", 32'(load_ovf0), 0);
        check("rst_prog_ready", 32'(if0.prog_ready), 0);
        check("rst_chk_ready", 32'(if0.chk_ready), 0);
        check("rst_mem_we", 32'(if0.mem_we), 0);
        check("rst_cpu_reset_small", 32'(cpu_reset1), 1);
`ifdef MCPU_SELFTEST_TRACE_EN
        check("rst_fail_count", 32'(fail_count0), 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Standard program with a 5-cycle stall mid-load, all checks matching
        base_clr = clr0; base_run = run0; base_ld = ld0;
        pulse_start(0);
        wait_for("clear_to_load", 0, 400);
        check("clear_writes", 32'(clr0 - base_clr), 256);
        check("clear_order_zero", 32'(clr_bad0), 0);
        load_program(0, 16, 1'b1, 1'b1, acc);
        check("load_accepted", 32'(acc), 16);
        check("load_writes", 32'(ld0 - base_ld), 16);
        check("ram_image", 32'(ram_diff(0, 16)), 0);
        check("ram_tail_cleared", 32'(ram0[200]), 0);
        check("std_no_ovf", 32'(load_ovf0), 0);
        wait_for("run_to_check", 1, 200);
        check("run_cycles", 32'(run0 - base_run), 57);
        n_took = 0;
        send_entry(0, 4'd4, 8'd100, 1'b0, took);  n_took += int'(took);
        send_entry(0, 4'd5, 8'd20, 1'b0, took);   n_took += int'(took);
        send_entry(0, 4'd10, 8'd40, 1'b0, took);  n_took += int'(took);
        send_entry(0, 4'd11, 8'd60, 1'b1, took);  n_took += int'(took);
        end_entries();
        check("std_entries", 32'(n_took), 4);
        check("std_done", 32'(done0), 1);
        check("std_pass", 32'(pass0), 1);
        check("std_busy", 32'(busy0), 0);
        check("std_cpu_reset", 32'(cpu_reset0), 1);
        check("idle_inst_ignores_prog", 32'(ld1), 0);

        // Rerun from DONE with a mismatching check list
        base_clr = clr0;
        pulse_start(0);
        wait_for("rerun_clear_to_load", 0, 400);
        check("rerun_clear_writes", 32'(clr0 - base_clr), 256);
        load_program(0, 16, 1'b1, 1'b0, acc);
        check("rerun_load_accepted", 32'(acc), 16);
        wait_for("rerun_run_to_check", 1, 200);
`ifdef MCPU_SELFTEST_TRACE_EN
        n_took = 0;
        send_entry(0, 4'd4, 8'd101, 1'b0, took);  n_took += int'(took);
        send_entry(0, 4'd5, 8'd21, 1'b0, took);   n_took += int'(took);
        send_entry(0, 4'd10, 8'd40, 1'b1, took);  n_took += int'(took);
        end_entries();
        check("trace_entries", 32'(n_took), 3);
        check("trace_done", 32'(done0), 1);
        check("trace_fail_count", 32'(fail_count0), 2);
        check("trace_first_reg", 32'(first_fail_reg0), 4);
        check("trace_first_data", 32'(first_fail_data0), 100);
        check("trace_pass", 32'(pass0), 0);
`else
        send_entry(0, 4'd4, 8'd101, 1'b0, took);
        check("mm_first_taken", 32'(took), 1);
        @(negedge clk);
        #1;
        check("mm_done_next_cycle", 32'(done0), 1);
        check("mm_chk_ready_low", 32'(if0.chk_ready), 0);
        chk_reg = 4'd5; chk_value = 8'd20; chk_last = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("mm_second_not_taken", 32'(if0.chk_ready), 0);
        check("mm_done_holds", 32'(done0), 1);
        check("mm_pass", 32'(pass0), 0);
        end_entries();
`endif

        // Asynchronous reset during RUN cycle 20
        pulse_start(0);
        wait_for("abort_clear_to_load", 0, 400);
        load_program(0, 16, 1'b1, 1'b0, acc);
        repeat (19) @(posedge clk);
        #1;
        check("abort_in_run", 32'(cpu_reset0), 0);
        #2;
        reset = 1'b1;
        #1;
        check("abort_cpu_reset", 32'(cpu_reset0), 1);
        check("abort_busy", 32'(busy0), 0);
        check("abort_done", 32'(done0), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("abort_stays_idle", 32'(busy0), 0);

        // Overflow on the 8-word instance
        base_clr = clr1; base_run = run1; base_ld = ld1;
        pulse_start(1);
        wait_for("ovf_clear_to_load", 2, 50);
        check("ovf_clear_writes", 32'(clr1 - base_clr), 8);
        check("ovf_clear_order_zero", 32'(clr_bad1), 0);
        load_program(1, 9, 1'b0, 1'b0, acc);
        check("ovf_accepted", 32'(acc), 8);
        check("ovf_writes", 32'(ld1 - base_ld), 8);
        check("ovf_ram_image", 32'(ram_diff(1, 8)), 0);
        check("ovf_flag", 32'(load_ovf1), 1);
        wait_for("ovf_run_to_check", 3, 200);
        check("ovf_run_cycles", 32'(run1 - base_run), 57);
        send_entry(1, 4'd4, 8'd100, 1'b1, took);
        end_entries();
        check("ovf_entry_taken", 32'(took), 1);
        check("ovf_done", 32'(done1), 1);
        check("ovf_pass", 32'(pass1), 0);
        check("ovf_flag_held", 32'(load_ovf1), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
